// File: rtl/adder_multi_cycle_16b_pkg.sv
// Shared constants for the multi-cycle 16-bit adder: FSM encoding and slice geometry.
// Imported by the RTL and by the testbench so both use the same encoding.
package adder_multi_cycle_16b_pkg;

    localparam int DATA_W     = 16;
    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = DATA_W / SLICE_W;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_CALC = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

endpackage

// File: rtl/adder_multi_cycle_16b_rca.sv
// Gate-level 4-bit ripple-carry adder, used as the single slice adder of the multi-cycle adder.
// The carry chain is written as separate nets so each bit's carry is an independent signal.
module AdderRippleCarry_4b_GL (
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic c1;
    logic c2;
    logic c3;

    assign sum[0] = in0[0] ^ in1[0] ^ cin;
    assign c1     = (in0[0] & in1[0]) | (cin & (in0[0] ^ in1[0]));
    assign sum[1] = in0[1] ^ in1[1] ^ c1;
    assign c2     = (in0[1] & in1[1]) | (c1 & (in0[1] ^ in1[1]));
    assign sum[2] = in0[2] ^ in1[2] ^ c2;
    assign c3     = (in0[2] & in1[2]) | (c2 & (in0[2] ^ in1[2]));
    assign sum[3] = in0[3] ^ in1[3] ^ c3;
    assign cout   = (in0[3] & in1[3]) | (c3 & (in0[3] ^ in1[3]));

endmodule

// File: rtl/adder_multi_cycle_16b.sv
// 16-bit adder that reuses one 4-bit ripple-carry slice over four CALC cycles.
// Control FSM and datapath live in separate blocks; dbg_state exposes the FSM.
module adder_multi_cycle_16b
    import adder_multi_cycle_16b_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        istream_val,
    output logic        istream_rdy,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic        cin,
    output logic        ostream_val,
    input  logic        ostream_rdy,
    output logic [15:0] sum,
    output logic        cout,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where val and rdy are both
    // high; the sender holds data stable while val is high and rdy is low.
    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [1:0]  k;
    logic        carry;
    logic [15:0] op0;
    logic [15:0] op1;
    logic [3:0]  slice_a;
    logic [3:0]  slice_b;
    logic [3:0]  slice_sum;
    logic        slice_cout;
    logic        in_xfer;
    logic        out_xfer;
    logic        calc_en;
    logic        calc_last;

    // ---------------- control ----------------
    assign istream_rdy = (state == STATE_IDLE);
    assign ostream_val = (state == STATE_DONE);
    assign in_xfer     = istream_val && istream_rdy;
    assign out_xfer    = ostream_val && ostream_rdy;
    assign calc_en     = (state == STATE_CALC);
    assign calc_last   = calc_en && (k == 2'd3);
    assign dbg_state   = state;

    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE: if (in_xfer)   state_next = STATE_CALC;
            STATE_CALC: if (calc_last) state_next = STATE_DONE;
            STATE_DONE: if (out_xfer)  state_next = STATE_IDLE;
            default:                   state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- datapath ----------------
    always_comb begin
        slice_a = op0[3:0];
        slice_b = op1[3:0];
        case (k)
            2'd1: begin slice_a = op0[7:4];   slice_b = op1[7:4];   end
            2'd2: begin slice_a = op0[11:8];  slice_b = op1[11:8];  end
            2'd3: begin slice_a = op0[15:12]; slice_b = op1[15:12]; end
            default: ;
        endcase
    end

    AdderRippleCarry_4b_GL u_slice_adder (
        .in0  (slice_a),
        .in1  (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op0   <= '0;
            op1   <= '0;
            k     <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (in_xfer) begin
            op0   <= in0;
            op1   <= in1;
            carry <= cin;
            k     <= '0;
        end else if (calc_en) begin
            case (k)
                2'd0:    sum[3:0]   <= slice_sum;
                2'd1:    sum[7:4]   <= slice_sum;
                2'd2:    sum[11:8]  <= slice_sum;
                default: sum[15:12] <= slice_sum;
            endcase
            carry <= slice_cout;
            k     <= k + 2'd1;
            if (calc_last) begin
                cout <= slice_cout;
            end
        end
    end

endmodule
